// File: rtl/delay_pipe_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : delay_pipe_ctrl_if
//  Description : Handshake, flush and status bundle for delay_pipe_ctrl.
//                Signal suffixes are relative to the controller: the slave
//                modport is the controller, and the master modport is the
//                surrounding logic that drives it.
//  Revision    : 1.0 - initial release
// ============================================================================
interface delay_pipe_ctrl_if #(
    parameter int Latency   = 4,
    parameter int StallBits = 16
);
    localparam int CountBits = $clog2(Latency + 1);

    logic                 flush_i;
    logic                 in_valid_i;
    logic                 in_ready_o;
    logic                 out_valid_o;
    logic                 out_ready_i;
    logic                 en_o;
    logic [CountBits-1:0] occupancy_o;
    logic                 busy_o;
    logic [StallBits-1:0] stall_cnt_o;

    modport slave (
        input  flush_i,
        input  in_valid_i,
        input  out_ready_i,
        output in_ready_o,
        output out_valid_o,
        output en_o,
        output occupancy_o,
        output busy_o,
        output stall_cnt_o
    );

    modport master (
        output flush_i,
        output in_valid_i,
        output out_ready_i,
        input  in_ready_o,
        input  out_valid_o,
        input  en_o,
        input  occupancy_o,
        input  busy_o,
        input  stall_cnt_o
    );
endinterface
`default_nettype wire

// File: rtl/delay_pipe_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : delay_pipe_ctrl
//  Description : Flow controller for a fixed-latency delay line whose stages
//                share a single enable. A valid shift register shadows the
//                datapath; the enable stalls the whole chain when the
//                consumer back-pressures. Provides flush, occupancy and a
//                saturating stall-cycle counter. Legal Latency: 1..64.
//  Revision    : 1.0 - initial release
// ============================================================================
module delay_pipe_ctrl #(
    parameter int Latency   = 4,
    parameter int StallBits = 16
) (
    input  wire               clk_i,
    input  wire               rst_i,
    delay_pipe_ctrl_if.slave  bus
);
    localparam int CountBits = $clog2(Latency + 1);

    localparam logic [CountBits-1:0] c_occ_one   = CountBits'(1);
    localparam logic [StallBits-1:0] c_stall_one = StallBits'(1);
    localparam logic [StallBits-1:0] c_stall_max = '1;

    logic [Latency-1:0]   v_q;
    logic [Latency-1:0]   v_d;
    logic [Latency-1:0]   v_shift;
    logic [CountBits-1:0] occ_q;
    logic [CountBits-1:0] occ_d;
    logic [StallBits-1:0] stall_q;
    logic [StallBits-1:0] stall_d;

    logic last_valid;
    logic en;
    logic accept;
    logic emit;
    logic stall_now;

    // The output stage valid bit drives the whole handshake.
    assign last_valid = v_q[Latency-1];

    // The chain advances unless flushing or the held output is refused.
    assign en        = !bus.flush_i && (!last_valid || bus.out_ready_i);
    assign accept    = bus.in_valid_i && en;
    assign emit      = last_valid && !bus.flush_i && bus.out_ready_i;
    assign stall_now = last_valid && !bus.out_ready_i && !bus.flush_i;

    assign bus.en_o        = en;
    assign bus.in_ready_o  = en;
    assign bus.out_valid_o = last_valid && !bus.flush_i;
    assign bus.occupancy_o = occ_q;
    assign bus.busy_o      = (occ_q != '0);
    assign bus.stall_cnt_o = stall_q;

    // A one-stage chain has nothing to shift from, so it takes the input bit.
    generate
        if (Latency == 1) begin : g_shift_single
            assign v_shift = bus.in_valid_i;
        end else begin : g_shift_multi
            assign v_shift = {v_q[Latency-2:0], bus.in_valid_i};
        end
    endgenerate

    // Next-state logic: flush wins, otherwise shift/count on handshake events.
    always_comb begin
        v_d     = v_q;
        occ_d   = occ_q;
        stall_d = stall_q;
        if (bus.flush_i) begin
            v_d     = '0;
            occ_d   = '0;
            stall_d = '0;
        end else begin
            if (en) begin
                v_d = v_shift;
            end
            if (accept && !emit) begin
                occ_d = occ_q + c_occ_one;
            end else if (emit && !accept) begin
                occ_d = occ_q - c_occ_one;
            end
            if (stall_now && (stall_q != c_stall_max)) begin
                stall_d = stall_q + c_stall_one;
            end
        end
    end

    // State registers; reset empties the pipe and clears statistics.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            v_q     <= '0;
            occ_q   <= '0;
            stall_q <= '0;
        end else begin
            v_q     <= v_d;
            occ_q   <= occ_d;
            stall_q <= stall_d;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_delay_pipe_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_delay_pipe_ctrl
//  Description : Directed self-checking bench for delay_pipe_ctrl with a
//                Latency=4 instance and a Latency=1 / 2-bit stall instance.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_delay_pipe_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;
    logic [4:0] exp_pat;

    always #5 clk = ~clk;

    delay_pipe_ctrl_if #(.Latency(4), .StallBits(16)) if4 ();
    delay_pipe_ctrl_if #(.Latency(1), .StallBits(2))  if1 ();

    delay_pipe_ctrl #(.Latency(4), .StallBits(16)) u_dut4 (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (if4.slave)
    );

    delay_pipe_ctrl #(.Latency(1), .StallBits(2)) u_dut1 (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (if1.slave)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Drive one cycle of the Latency=4 instance; returns settled, before the edge.
    task automatic cyc4(input logic iv, input logic ordy, input logic fl);
        @(negedge clk);
        if4.in_valid_i  = iv;
        if4.out_ready_i = ordy;
        if4.flush_i     = fl;
        #1;
    endtask

    task automatic cyc1(input logic iv, input logic ordy);
        @(negedge clk);
        if1.in_valid_i  = iv;
        if1.out_ready_i = ordy;
        if1.flush_i     = 1'b0;
        #1;
    endtask

    initial begin
        if4.in_valid_i = 0; if4.out_ready_i = 0; if4.flush_i = 0;
        if1.in_valid_i = 0; if1.out_ready_i = 0; if1.flush_i = 0;

        // Reset state
        #1;
        chk("rst_occ",  32'(if4.occupancy_o), 0);
        chk("rst_ov",   32'(if4.out_valid_o), 0);
        chk("rst_busy", 32'(if4.busy_o),      0);
        chk("rst_en",   32'(if4.en_o),        1);
        chk("rst_ir",   32'(if4.in_ready_o),  1);
        chk("rst_stl",  32'(if4.stall_cnt_o), 0);
        @(negedge clk);
        rst = 1'b0;

        // 1: single pulse
        cyc4(1, 1, 0);
        chk("t1_occ0", 32'(if4.occupancy_o), 0);
        chk("t1_ir0",  32'(if4.in_ready_o),  1);
        chk("t1_ov0",  32'(if4.out_valid_o), 0);
        for (int k = 1; k <= 3; k++) begin
            cyc4(0, 1, 0);
            chk("t1_occ", 32'(if4.occupancy_o), 1);
            chk("t1_ov",  32'(if4.out_valid_o), 0);
        end
        cyc4(0, 1, 0);
        chk("t1_ov4",  32'(if4.out_valid_o), 1);
        chk("t1_occ4", 32'(if4.occupancy_o), 1);
        cyc4(0, 1, 0);
        chk("t1_ov5",   32'(if4.out_valid_o), 0);
        chk("t1_occ5",  32'(if4.occupancy_o), 0);
        chk("t1_busy5", 32'(if4.busy_o),      0);

        // 2: continuous stream of 10 items
        for (int k = 0; k <= 14; k++) begin
            cyc4(k < 10, 1, 0);
            chk("t2_ov",  32'(if4.out_valid_o), (k >= 4 && k <= 13) ? 1 : 0);
            chk("t2_occ", 32'(if4.occupancy_o), (k < 4) ? k : (k <= 10 ? 4 : 14 - k));
            chk("t2_ir",  32'(if4.in_ready_o),  1);
        end

        // 3: fill, then back-pressure for 5 cycles
        for (int k = 0; k < 4; k++) cyc4(1, 1, 0);
        for (int j = 0; j < 5; j++) begin
            cyc4(1, 0, 0);
            chk("t3_en",  32'(if4.en_o),        0);
            chk("t3_ir",  32'(if4.in_ready_o),  0);
            chk("t3_ov",  32'(if4.out_valid_o), 1);
            chk("t3_occ", 32'(if4.occupancy_o), 4);
            chk("t3_stl", 32'(if4.stall_cnt_o), j);
        end
        for (int j = 0; j < 4; j++) begin
            cyc4(0, 1, 0);
            chk("t3_drain_ov", 32'(if4.out_valid_o), 1);
            chk("t3_stl5",     32'(if4.stall_cnt_o), 5);
        end
        cyc4(0, 1, 0);
        chk("t3_occ_end", 32'(if4.occupancy_o), 0);
        chk("t3_ov_end",  32'(if4.out_valid_o), 0);

        // Flush clears the stall statistic
        cyc4(0, 1, 1);
        chk("fl_en", 32'(if4.en_o),       0);
        chk("fl_ir", 32'(if4.in_ready_o), 0);

        // 4: bubble pattern 1,0,1,0 with a 2-cycle stall at the output
        cyc4(1, 1, 0);
        chk("t4_stl0", 32'(if4.stall_cnt_o), 0);
        cyc4(0, 1, 0);
        cyc4(1, 1, 0);
        cyc4(0, 1, 0);
        for (int j = 0; j < 2; j++) begin
            cyc4(0, 0, 0);
            chk("t4_hold_ov", 32'(if4.out_valid_o), 1);
            chk("t4_hold_en", 32'(if4.en_o),        0);
        end
        exp_pat = 5'b00101;
        for (int k = 0; k < 5; k++) begin
            cyc4(0, 1, 0);
            chk("t4_seq", 32'(if4.out_valid_o), 32'(exp_pat[k]));
        end
        chk("t4_stl2", 32'(if4.stall_cnt_o), 2);

        // 5: flush with occupancy 3 and output valid
        cyc4(1, 1, 0);
        cyc4(1, 1, 0);
        cyc4(1, 1, 0);
        cyc4(0, 1, 0);
        cyc4(1, 1, 1);
        chk("t5_ov",   32'(if4.out_valid_o), 0);
        chk("t5_ir",   32'(if4.in_ready_o),  0);
        chk("t5_occ",  32'(if4.occupancy_o), 3);
        chk("t5_stl",  32'(if4.stall_cnt_o), 2);
        cyc4(0, 1, 0);
        chk("t5_occ0",  32'(if4.occupancy_o), 0);
        chk("t5_busy0", 32'(if4.busy_o),      0);
        chk("t5_stl0",  32'(if4.stall_cnt_o), 0);
        chk("t5_ov0",   32'(if4.out_valid_o), 0);

        // 6: asynchronous reset mid-stream
        cyc4(1, 1, 0);
        cyc4(1, 1, 0);
        cyc4(0, 1, 0);
        cyc4(0, 1, 0);
        cyc4(0, 1, 0);
        chk("t6_ov_pre",  32'(if4.out_valid_o), 1);
        chk("t6_occ_pre", 32'(if4.occupancy_o), 2);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_ov",   32'(if4.out_valid_o), 0);
        chk("t6_busy", 32'(if4.busy_o),      0);
        chk("t6_occ",  32'(if4.occupancy_o), 0);
        chk("t6_en",   32'(if4.en_o),        1);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            cyc4(0, 1, 0);
            chk("t6_no_out", 32'(if4.out_valid_o), 0);
        end

        // Latency=1 instance with a 2-bit saturating stall counter
        cyc1(1, 1);
        chk("l1_ir0", 32'(if1.in_ready_o),  1);
        chk("l1_ov0", 32'(if1.out_valid_o), 0);
        cyc1(1, 1);
        chk("l1_ov1",  32'(if1.out_valid_o), 1);
        chk("l1_ir1",  32'(if1.in_ready_o),  1);
        chk("l1_occ1", 32'(if1.occupancy_o), 1);
        cyc1(0, 0);
        chk("l1_ov2",  32'(if1.out_valid_o), 1);
        chk("l1_en2",  32'(if1.en_o),        0);
        chk("l1_stl2", 32'(if1.stall_cnt_o), 0);
        for (int j = 1; j <= 4; j++) begin
            cyc1(0, 0);
            chk("l1_stl_sat", 32'(if1.stall_cnt_o), (j < 3) ? j : 3);
        end
        cyc1(0, 1);
        chk("l1_ov7", 32'(if1.out_valid_o), 1);
        chk("l1_ir7", 32'(if1.in_ready_o),  1);
        cyc1(0, 1);
        chk("l1_ov8",  32'(if1.out_valid_o), 0);
        chk("l1_occ8", 32'(if1.occupancy_o), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
